// File: rtl/store_align.sv
// store_align
//
// Purpose:
//   Narrows a 64-bit register value into 8-byte-aligned memory write beats
//   for the data-memory write port.
//   This is the store-side mirror of the load sign-extension logic.
//   A store whose bytes straddle an 8-byte boundary is split into two beats.
//   With ALLOW_MISALIGNED=0, a store whose address is not a multiple of its
//   size is rejected instead of being written.
//
// Parameters:
//   ADDR_WIDTH        byte address width (must be at least 4)
//   ALLOW_MISALIGNED  1: split boundary-crossing stores; 0: reject misaligned
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_valid        store request valid
//   o_ready        block can accept a request (IDLE and out of reset)
//   i_addr         byte address of the store
//   i_data         register value; only the low 2^i_size bytes are written
//   i_size         00 byte, 01 half, 10 word, 11 double
//   o_mem_valid    write beat valid
//   i_mem_ready    memory accepts the beat
//   o_mem_addr     8-byte-aligned beat address
//   o_mem_wdata    beat write data (unenabled lanes are zero)
//   o_mem_be       byte enables, bit k = byte lane k
//   o_done         one-cycle pulse after the final beat handshake
//   o_misaligned   one-cycle pulse when a store is rejected
module store_align #(
    parameter int ADDR_WIDTH       = 64,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [63:0]           i_data,
    input  logic [1:0]            i_size,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [63:0]           o_mem_wdata,
    output logic [7:0]            o_mem_be,
    output logic                  o_done,
    output logic                  o_misaligned
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT0  = 2'd1,
        BEAT1  = 2'd2,
        REJECT = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [127:0]            sh_q;
    logic [15:0]             be_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    done_q;

    logic                    accept;
    logic                    final_hs;
    logic [3:0]              n_bytes;
    logic [2:0]              off;
    logic [63:0]             data_masked;
    logic [127:0]            sh_d;
    logic [15:0]             be_d;
    logic                    misaligned;

    assign accept = i_valid && o_ready;

    // Decode the incoming request into its full 16-lane image.
    // The low 8 lanes form the first beat and the high 8 lanes form the
    // second beat. Bytes above the access size are zeroed before shifting,
    // so lanes that are not enabled always carry zero.
    // For a double-word, n_bytes[2:0] is 0, so the alignment mask becomes 7
    // and the whole offset is checked.
    always_comb begin
        n_bytes     = 4'd1 << i_size;
        off         = i_addr[2:0];
        data_masked = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(n_bytes)) begin
                data_masked[8*k +: 8] = i_data[8*k +: 8];
            end
        end
        sh_d        = {64'b0, data_masked} << {off, 3'b000};
        be_d        = ((16'd1 << n_bytes) - 16'd1) << off;
        misaligned  = (off & (n_bytes[2:0] - 3'd1)) != 3'd0;
    end

    // State register.
    // Reset is asynchronous, so o_mem_valid drops as soon as reset asserts.
    // Any pending beat is simply abandoned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A second beat is only taken when the shifted byte enables spill into
    // the upper eight lanes. final_hs marks the handshake that completes a
    // store, and it feeds the registered o_done pulse.
    always_comb begin
        state_next = state;
        final_hs   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!ALLOW_MISALIGNED && misaligned) begin
                        state_next = REJECT;
                    end else begin
                        state_next = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (i_mem_ready) begin
                    if (be_q[15:8] != 8'h00) begin
                        state_next = BEAT1;
                    end else begin
                        state_next = IDLE;
                        final_hs   = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (i_mem_ready) begin
                    state_next = IDLE;
                    final_hs   = 1'b1;
                end
            end
            REJECT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture and done pulse.
    // The shifted data, lane enables and base address are captured once at
    // accept. Both beats are then just slices of this captured image, so
    // they stay stable under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_q   <= '0;
            be_q   <= '0;
            base_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= final_hs;
            if (accept) begin
                sh_q   <= sh_d;
                be_q   <= be_d;
                base_q <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
            end
        end
    end

    // Output decode.
    // Beat fields are driven only in beat states and are zero otherwise.
    // o_ready is qualified with i_rst_n, so it is low for the whole time
    // reset is held. The second beat address wraps naturally at the top of
    // the address space.
    always_comb begin
        o_ready      = (state == IDLE) && i_rst_n;
        o_mem_valid  = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        o_misaligned = (state == REJECT);
        o_done       = done_q;
        case (state)
            BEAT0: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = base_q;
                o_mem_wdata = sh_q[63:0];
                o_mem_be    = be_q[7:0];
            end
            BEAT1: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = base_q + ADDR_WIDTH'(8);
                o_mem_wdata = sh_q[127:64];
                o_mem_be    = be_q[15:8];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/store_align.md
Name: store_align

Overview:
- Store-path counterpart to the immediate/load sign-extension logic. Sign-extension widens narrow values to 64 bits; this block narrows them for memory writes.
- Takes a 64-bit register value, a byte address and an access size (byte/half/word/double) from the execute stage.
- Produces 8-byte-aligned write beats with byte enables on the data-memory write port.
- Splits stores that cross an 8-byte boundary into two beats. Uses valid/ready handshakes on both sides.

Parameters:
- ADDR_WIDTH, 64, width of byte address in and aligned address out.
- ALLOW_MISALIGNED, 1. If 1, boundary-crossing stores are split into two beats. If 0, any store whose address is not a multiple of its size is rejected with o_misaligned.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  store request valid
- o_ready  out  1  block can accept a request
- i_addr  in  ADDR_WIDTH  byte address of store
- i_data  in  64  register value; only the low 2^i_size bytes are used
- i_size  in  2  00 byte, 01 half, 10 word, 11 double
- o_mem_valid  out  1  write beat valid
- i_mem_ready  in  1  memory accepts beat
- o_mem_addr  out  ADDR_WIDTH  8-byte-aligned beat address (low 3 bits always 0)
- o_mem_wdata  out  64  beat write data
- o_mem_be  out  8  byte enables, bit k = byte lane k
- o_done  out  1  1-cycle pulse: store fully written
- o_misaligned  out  1  1-cycle pulse: store rejected (only when ALLOW_MISALIGNED=0)

Behaviour:
- Reset: while i_rst_n=0, state=IDLE and all outputs are 0, including o_ready. Registers clear immediately, not on the clock edge. After release, o_ready=1.
- States: IDLE, BEAT0, BEAT1, REJECT.
- o_ready = (state==IDLE) && i_rst_n.
- Accept: request is taken on a rising edge with i_valid && o_ready. At that edge the block latches addr, data and size, and computes:
  - n = 1<<size bytes
  - off = addr[2:0]
  - sh = {64'b0, data masked to n bytes} << (8*off), 128 bits
  - be16 = ((1<<n)-1) << off, 16 bits
  - base = {addr[ADDR_WIDTH-1:3], 3'b000}
- Transition out of IDLE on accept: if ALLOW_MISALIGNED=0 and addr mod n != 0, go to REJECT. Otherwise go to BEAT0.
- BEAT0: o_mem_valid=1, o_mem_addr=base, o_mem_wdata=sh[63:0], o_mem_be=be16[7:0]. Unenabled bytes of wdata are 0.
- BEAT1: o_mem_valid=1, o_mem_addr=base+8 modulo 2^ADDR_WIDTH (wraps to 0), o_mem_wdata=sh[127:64], o_mem_be=be16[15:8].
- Beat outputs stay stable while o_mem_valid && !i_mem_ready. No beat is ever dropped or repeated.
- On handshake in BEAT0: go to BEAT1 if be16[15:8]!=0, otherwise go to IDLE. On handshake in BEAT1: go to IDLE.
- o_done pulses for 1 cycle, registered, the cycle after the final beat handshake (state already IDLE, o_ready=1 in that cycle). A new request may be accepted in that same cycle.
- REJECT: lasts 1 cycle with o_misaligned=1, o_mem_valid=0, o_done=0, then IDLE.
- Minimum latency: accept at edge N; o_mem_valid high in cycle N+1; with i_mem_ready=1, o_done in cycle N+2 for one beat, N+3 for two beats.
- A double-word at offset 0 is one beat with be=0xFF. The maximum is 2 beats per store.
- Reset mid-operation: the pending beat is abandoned, o_mem_valid drops immediately, and no o_done is issued.

Test Plan:
- Byte store: size=00, addr=0x1003, data=0xFFFF_FFFF_FFFF_FFAB -> one beat, addr 0x1000, wdata 0x0000_0000_AB00_0000, be 0x08; o_done 2 cycles after accept.
- Split word: ALLOW_MISALIGNED=1, size=10, addr=0x1006, data=0xDEADBEEF -> beat0 addr 0x1000, wdata 0xBEEF_0000_0000_0000, be 0xC0; beat1 addr 0x1008, wdata 0x0000_0000_0000_DEAD, be 0x03; single o_done pulse.
- Backpressure: size=11, addr=0x2000, data=0x0123_4567_89AB_CDEF, i_mem_ready low for 3 cycles -> addr/wdata/be=0xFF held stable for 4 cycles; o_done the cycle after ready; o_ready low throughout.
- Address wrap: size=01, addr=0xFFFF_FFFF_FFFF_FFFF, data=0x1234 -> beat0 addr 0xFFFF_FFFF_FFFF_FFF8, wdata 0x3400_0000_0000_0000, be 0x80; beat1 addr 0x0, wdata 0x12, be 0x01.
- Reject: ALLOW_MISALIGNED=0, size=10, addr=0x1002 -> o_misaligned pulse 1 cycle after accept; o_mem_valid never asserted; no o_done; o_ready back to 1 the next cycle.
- Reset mid-op: drop i_rst_n while in BEAT1 with i_mem_ready=0 -> o_mem_valid=0 without a clock edge; no o_done; o_ready=1 after release; a following aligned store completes normally.
